instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, word address width of the target instruction memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width; DATA_WIDTH is fixed at 32 (4 bytes per word).
REQ-003 SHALL have one clock and an asynchronous active-low reset; there are no other clocks.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-007 len  input  ADDRESS_WIDTH+1  number of words to load; sampled together with start.
REQ-008 byte_valid  input  1  byte_data is valid this cycle.
REQ-009 byte_data  input  8  incoming program byte, little-endian within each word.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-011 WE  output  1  write enable to the instruction memory.
REQ-012 A  output  ADDRESS_WIDTH  write word address.
REQ-013 WD  output  DATA_WIDTH  write data word.
REQ-014 busy  output  1  load in progress; asserted in every state except IDLE and DONE.
REQ-015 done  output  1  load complete; held until the next accepted start.
REQ-016 cpu_rst_n  output  1  active-low reset to the CPU core; 0 while busy or under reset, else 1.

Function
REQ-017 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-018 IDLE: byte_ready=0 and WE=0; on start=1, the loader SHALL latch len, clear the word address and byte index, and clear done.
  - If the latched len is 0, the next state is DONE.
  - Otherwise, the next state is RECV.
REQ-019 The latched len SHALL saturate to 2**ADDRESS_WIDTH when it exceeds that value.
REQ-020 RECV: byte_ready=1.
  - Each transfer SHALL store byte_data into byte lane [8*idx+7:8*idx] of the word buffer and increment idx (2 bits).
  - On the transfer with idx=3, the next state is WRITE.
REQ-021 WRITE: exactly one cycle, with WE=1, A equal to the current word address, and WD equal to the assembled word; byte_ready=0.
  - The next edge SHALL increment the word address and the word counter.
  - The next state is DONE when the counter reaches the latched len; otherwise it is RECV.
REQ-022 WE SHALL be 0 in every state except WRITE.
  - A and WD SHALL be registered outputs.
  - The memory write occurs on the clk edge that ends the WRITE cycle.
REQ-023 Throughput SHALL be at most one word per 5 cycles: 4 transfer cycles plus 1 WRITE cycle.
  - Gaps where byte_valid=0 SHALL stall RECV indefinitely without losing partial bytes.
REQ-024 DONE: done=1, busy=0, byte_ready=0; a new start SHALL begin a fresh load exactly as from IDLE.
REQ-025 start asserted while busy SHALL be ignored, with no effect on len, the address or the state.
REQ-026 Bytes presented while byte_ready=0 SHALL be ignored and not consumed.
REQ-027 The word address SHALL wrap modulo 2**ADDRESS_WIDTH; saturation of len guarantees no address is written twice in one load.
REQ-028 A load of exactly 2**ADDRESS_WIDTH words SHALL write addresses 0 through 2**ADDRESS_WIDTH-1 and terminate correctly; the counter is ADDRESS_WIDTH+1 bits wide.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force:
  - state=IDLE and WE=0;
  - A=0, WD=0 and the byte index to 0;
  - byte_ready=0, busy=0, done=0 and cpu_rst_n=0.
REQ-030 After rst_n returns high, the loader SHALL sit in IDLE with cpu_rst_n=1 until start.
REQ-031 Reset asserted mid-load SHALL abort the load; partial bytes are discarded and no further WE pulse occurs.

Verification
REQ-032 start, len=2; bytes 13,00,00,00 then 93,00,10,00 back-to-back -> WE pulses at A=0 with WD=0x00000013 and at A=1 with WD=0x00100093; done=1 at cycle 11 after start; busy 1->0; cpu_rst_n 0->1.
REQ-033 start, len=0 -> DONE on the next edge; no WE pulse; done=1.
REQ-034 len=1 with byte_valid toggling every other cycle (bytes EF,BE,AD,DE) -> a single WE with WD=0xDEADBEEF at A=0; byte order is unaffected by the stalls.
REQ-035 start pulsed again during RECV with len=5 -> ignored; the load completes with the original len.
REQ-036 rst_n dropped after 2 bytes of word 1 in a len=3 load -> all outputs go to their reset values asynchronously; a fresh start then writes from A=0.
REQ-037 ADDRESS_WIDTH=2, len=7 -> saturates to 4; writes A=0,1,2,3 once each, then done=1.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction loader: assembles little-endian bytes into 32-bit words
// and writes them to instruction memory while holding the CPU in reset.
module instr_loader #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   len,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     WE,
    output logic [ADDRESS_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0]    WD,
    output logic                     busy,
    output logic                     done,
    output logic                     cpu_rst_n
);

    localparam logic [ADDRESS_WIDTH:0] MAX_LEN =
        {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH:0]   len_q, len_d;
    logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDRESS_WIDTH:0]   len_sat;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]               idx_q, idx_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;

    // A load never exceeds the memory size, so no address is written twice
    assign len_sat = (len > MAX_LEN) ? MAX_LEN : len;

    // State and datapath registers; reset aborts any load in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state: start only in IDLE/DONE, byte packing in RECV, step in WRITE
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d   = len_sat;
                    cnt_d   = '0;
                    addr_d  = '0;
                    idx_d   = '0;
                    state_d = (len_sat == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byte_valid) begin
                    wd_d[{idx_q, 3'b000} +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_ONE;
                cnt_d   = cnt_q + CNT_ONE;
                state_d = (cnt_q + CNT_ONE == len_q) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready = (state_q == RECV);
    assign WE         = (state_q == WRITE);
    assign A          = addr_q;
    assign WD         = wd_q;
    assign busy       = (state_q == RECV) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign cpu_rst_n  = rst_n & ~busy;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: random byte streams checked against a
// word-level model of which memory words a load must produce.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, byte_valid, sel;
    logic [8:0] len;
    logic [7:0] byte_data;

    logic        br8, we8, busy8, done8, crn8;
    logic [7:0]  a8;
    logic [31:0] wd8;
    logic        br2, we2, busy2, done2, crn2;
    logic [1:0]  a2;
    logic [31:0] wd2;

    instr_loader dut8 (
        .clk(clk), .rst_n(rst_n),
        .start(start & ~sel), .len(len),
        .byte_valid(byte_valid & ~sel), .byte_data(byte_data),
        .byte_ready(br8), .WE(we8), .A(a8), .WD(wd8),
        .busy(busy8), .done(done8), .cpu_rst_n(crn8)
    );

    instr_loader #(.ADDRESS_WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .start(start & sel), .len(len[2:0]),
        .byte_valid(byte_valid & sel), .byte_data(byte_data),
        .byte_ready(br2), .WE(we2), .A(a2), .WD(wd2),
        .busy(busy2), .done(done2), .cpu_rst_n(crn2)
    );

    logic        s_rdy, s_we, s_busy, s_done, s_crn;
    logic [7:0]  s_a;
    logic [31:0] s_wd;
    assign s_rdy  = sel ? br2   : br8;
    assign s_we   = sel ? we2   : we8;
    assign s_busy = sel ? busy2 : busy8;
    assign s_done = sel ? done2 : done8;
    assign s_crn  = sel ? crn2  : crn8;
    assign s_a    = sel ? {6'b0, a2} : a8;
    assign s_wd   = sel ? wd2   : wd8;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0]  stim_q[$];
    int          cap_a[$];
    logic [31:0] cap_d[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_we === 1'b1) begin
            cap_a.push_back(int'(s_a));
            cap_d.push_back(s_wd);
        end
    end

    task automatic run_load(input bit use2, input int ln, input int gap_mode,
                            input int inj_after, output int lat);
        int aw;
        int nw;
        int st;
        int w;
        int g;
        logic [31:0] exp_d;
        aw = use2 ? 2 : 8;
        nw = (ln > (1 << aw)) ? (1 << aw) : ln;
        lat = -1;
        while (stim_q.size() < 4 * nw) stim_q.push_back(8'($urandom));
        cap_a.delete();
        cap_d.delete();
        @(negedge clk);
        sel = use2;
        start = 1'b1;
        len = 9'(ln);
        st = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        if (nw > 0) begin
            n_vec++;
            if (s_busy !== 1'b1 || s_crn !== 1'b0) begin
                n_err++;
                $display("FAIL busy_start: busy=%b cpu_rst_n=%b want 1/0",
                         s_busy, s_crn);
            end
        end
        for (int i = 0; i < 4 * nw; i++) begin
            g = (gap_mode == 1 && i > 0) ? 1 :
                (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                byte_valid = 1'b0;
                byte_data = 8'($urandom);
                @(negedge clk);
            end
            if (i == inj_after) begin
                byte_valid = 1'b0;
                start = 1'b1;
                len = 9'd5;
                @(negedge clk);
                start = 1'b0;
                len = 9'(ln);
            end
            byte_valid = 1'b1;
            byte_data = stim_q[i];
            w = 0;
            while (s_rdy !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) begin
                n_vec++;
                n_err++;
                $display("FAIL byte_timeout: byte %0d ready=%b want 1",
                         i, s_rdy);
                break;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        w = 0;
        while (s_done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        lat = cyc - st + 1;
        n_vec++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || s_crn !== 1'b1 ||
            s_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL end_state: done=%b busy=%b crn=%b rdy=%b want 1010",
                     s_done, s_busy, s_crn, s_rdy);
        end
        n_vec++;
        if (cap_a.size() !== nw) begin
            n_err++;
            $display("FAIL write_count: got %0d want %0d", cap_a.size(), nw);
        end
        for (int k = 0; k < nw && k < cap_a.size(); k++) begin
            exp_d = {stim_q[4*k+3], stim_q[4*k+2], stim_q[4*k+1], stim_q[4*k]};
            n_vec++;
            if (cap_a[k] !== (k % (1 << aw)) || cap_d[k] !== exp_d) begin
                n_err++;
                $display("FAIL write_%0d: A=%0d WD=%h want A=%0d WD=%h",
                         k, cap_a[k], cap_d[k], k % (1 << aw), exp_d);
            end
        end
        stim_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({br8, we8, busy8, done8, crn8} !== 5'b0 || a8 !== 8'd0 ||
            wd8 !== 32'd0) begin
            n_err++;
            $display("FAIL reset8: rdy/we/busy/done/crn=%b A=%h WD=%h want 0",
                     {br8, we8, busy8, done8, crn8}, a8, wd8);
        end
        n_vec++;
        if ({br2, we2, busy2, done2, crn2} !== 5'b0 || a2 !== 2'd0 ||
            wd2 !== 32'd0) begin
            n_err++;
            $display("FAIL reset2: flags=%b A=%h WD=%h want 0",
                     {br2, we2, busy2, done2, crn2}, a2, wd2);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (crn8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 ||
            br8 !== 1'b0 || we8 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: crn=%b busy=%b done=%b want 1/0/0",
                     crn8, busy8, done8);
        end
    endtask

    task automatic test_basic();
        int lat;
        stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(1'b0, 2, 0, -1, lat);
        n_vec++;
        if (lat !== 11) begin
            n_err++;
            $display("FAIL basic_latency: done at cycle %0d want 11", lat);
        end
    endtask

    task automatic test_len_zero();
        int lat;
        run_load(1'b0, 0, 0, -1, lat);
        n_vec++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL len0_latency: done at cycle %0d want 1", lat);
        end
    endtask

    task automatic test_stall();
        int lat;
        stim_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(1'b0, 1, 1, -1, lat);
    endtask

    task automatic test_start_ignored();
        int lat;
        run_load(1'b0, 2, 0, 2, lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        int w;
        logic [31:0] exp_d;
        cap_a.delete();
        cap_d.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
        @(negedge clk);
        sel = 1'b0;
        start = 1'b1;
        len = 9'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1;
            byte_data = stim_q[i];
            w = 0;
            while (br8 !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({br8, we8, busy8, done8, crn8} !== 5'b0 || a8 !== 8'd0 ||
            wd8 !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: flags=%b A=%h WD=%h want 0",
                     {br8, we8, busy8, done8, crn8}, a8, wd8);
        end
        exp_d = {stim_q[3], stim_q[2], stim_q[1], stim_q[0]};
        n_vec++;
        if (cap_a.size() !== 1 || cap_d[0] !== exp_d) begin
            n_err++;
            $display("FAIL aborted_writes: count=%0d want 1 (WD want %h)",
                     cap_a.size(), exp_d);
        end
        stim_q.delete();
        repeat (3) @(negedge clk);
        n_vec++;
        if (cap_a.size() !== 1) begin
            n_err++;
            $display("FAIL we_during_reset: count=%0d want 1", cap_a.size());
        end
        rst_n = 1'b1;
        run_load(1'b0, 1, 0, -1, lat);
    endtask

    task automatic test_saturate();
        int lat;
        run_load(1'b1, 7, 0, -1, lat);
        run_load(1'b1, 4, 2, -1, lat);
        run_load(1'b0, 300, 0, -1, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int k = 0; k < 8; k++) begin
            run_load(k[0], int'($urandom_range(0, k[0] ? 7 : 6)), 2, -1, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        len = 9'd0;
        sel = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
